// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the fetch/data memory arbiter.
//   - arb_state_t : FSM state encoding (IDLE=0, BUSY_I=1, BUSY_D=2)
//   - ARB_*       : default parameter values used by the arbiter
//   - sat_inc     : saturating increment helper for the starvation counter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam int ARB_ADDR_W    = 32;
  localparam int ARB_DATA_W    = 32;
  localparam int ARB_MAX_D_RUN = 4;

  // Increment by one but never past the given ceiling.
  function automatic logic [7:0] sat_inc(input logic [7:0] value,
                                         input logic [7:0] ceiling);
    sat_inc = (value >= ceiling) ? ceiling : value + 8'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a single-ported backend memory between the fetch stage
//   (read-only port i_*) and the memory stage (read/write port d_*).
//   Data requests normally win, but after MAX_D_RUN consecutive data grants
//   made while a fetch was waiting, the fetch is granted next.
//   Every transaction returns to IDLE for one cycle before the next grant.
//
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous, active-low reset
//   i_req    in   fetch request, held until i_ready
//   i_addr   in   fetch address
//   i_rdata  out  fetched word, valid with i_ready
//   i_ready  out  one-cycle fetch completion pulse
//   d_req    in   data request, held until d_ready
//   d_we     in   data write enable (1=write)
//   d_addr   in   data address
//   d_wdata  in   data write value
//   d_rdata  out  data read value, valid with d_ready (held across writes)
//   d_ready  out  one-cycle data completion pulse
//   m_req    out  backend request, held until m_ack
//   m_we     out  backend write enable
//   m_addr   out  backend address
//   m_wdata  out  backend write data
//   m_rdata  in   backend read data, valid with m_ack
//   m_ack    in   backend completion
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MAX_D_RUN = ARB_MAX_D_RUN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_D_RUN);

  arb_state_t        state, state_next;
  logic [CNT_W-1:0]  run_cnt, run_cnt_next;
  logic              m_req_next, m_we_next;
  logic [ADDR_W-1:0] m_addr_next;
  logic [DATA_W-1:0] m_wdata_next;
  logic              i_ready_next, d_ready_next;
  logic [DATA_W-1:0] i_rdata_next, d_rdata_next;
  logic              fetch_due;

  // A waiting fetch overrides data once the data run has hit its limit.
  assign fetch_due = i_req && (run_cnt == MAX_CNT);

  // Next-state and next-output logic. Backend request fields are only
  // loaded on a grant, so they stay stable for the whole BUSY phase.
  always_comb begin
    state_next   = state;
    run_cnt_next = run_cnt;
    m_req_next   = m_req;
    m_we_next    = m_we;
    m_addr_next  = m_addr;
    m_wdata_next = m_wdata;
    i_ready_next = 1'b0;
    d_ready_next = 1'b0;
    i_rdata_next = i_rdata;
    d_rdata_next = d_rdata;

    case (state)
      IDLE: begin
        // m_ack is deliberately ignored here
        if (d_req && !fetch_due) begin
          state_next   = BUSY_D;
          m_req_next   = 1'b1;
          m_we_next    = d_we;
          m_addr_next  = d_addr;
          m_wdata_next = d_wdata;
          // only runs taken while a fetch is waiting count toward starvation
          run_cnt_next = i_req ? sat_inc(run_cnt, MAX_CNT) : '0;
        end else if (i_req) begin
          state_next   = BUSY_I;
          m_req_next   = 1'b1;
          m_we_next    = 1'b0;
          m_addr_next  = i_addr;
          m_wdata_next = '0;
          run_cnt_next = '0;
        end
      end

      BUSY_I: begin
        if (m_ack) begin
          state_next   = IDLE;
          m_req_next   = 1'b0;
          i_ready_next = 1'b1;
          i_rdata_next = m_rdata;
        end
      end

      BUSY_D: begin
        if (m_ack) begin
          state_next   = IDLE;
          m_req_next   = 1'b0;
          d_ready_next = 1'b1;
          // a write completion leaves the last read value in place
          if (!m_we) begin
            d_rdata_next = m_rdata;
          end
        end
      end

      default: begin
        state_next = IDLE;
        m_req_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately,
  // including an in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      run_cnt <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state   <= state_next;
      run_cnt <= run_cnt_next;
      m_req   <= m_req_next;
      m_we    <= m_we_next;
      m_addr  <= m_addr_next;
      m_wdata <= m_wdata_next;
      i_ready <= i_ready_next;
      d_ready <= d_ready_next;
      i_rdata <= i_rdata_next;
      d_rdata <= d_rdata_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Requests are queued as expected
//   backend transactions when driven; each grant is checked against the
//   queue head and each completion pops it and checks ready/rdata against
//   a small rdata model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_req, m_we;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_i_rdata = '0;
  logic [31:0] model_d_rdata = '0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input logic is_data, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.is_data = is_data;
    t.we      = we;
    t.addr    = addr;
    t.wdata   = wdata;
    exp_q.push_back(t);
  endtask

  task automatic apply_stimulus(input logic is_data, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    push_expect(is_data, we, addr, wdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_m_req"},   64'(m_req),   64'd0);
    check_output({tag, "_m_we"},    64'(m_we),    64'd0);
    check_output({tag, "_m_addr"},  64'(m_addr),  64'd0);
    check_output({tag, "_m_wdata"}, 64'(m_wdata), 64'd0);
    check_output({tag, "_i_ready"}, 64'(i_ready), 64'd0);
    check_output({tag, "_d_ready"}, 64'(d_ready), 64'd0);
    check_output({tag, "_i_rdata"}, 64'(i_rdata), 64'd0);
    check_output({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
    check_output({tag, "_state"},   64'(dut.state), 64'(IDLE));
  endtask

  // Waits (bounded) for the backend request and checks it against the queue head.
  task automatic wait_grant();
    txn_t t;
    int   n = 0;
    while (m_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("grant_seen", 64'(m_req), 64'd1);
    if (exp_q.size() == 0) begin
      check_output("grant_expected", 64'd0, 64'd1);
    end else begin
      t = exp_q[0];
      check_output("grant_we", 64'(m_we), t.is_data ? 64'(t.we) : 64'd0);
      check_output("grant_addr", 64'(m_addr), 64'(t.addr));
      if (t.is_data && t.we) check_output("grant_wdata", 64'(m_wdata), 64'(t.wdata));
    end
  endtask

  // Acks after lat cycles, then checks the completion one edge later.
  task automatic complete(input int lat, input logic [31:0] rdata);
    txn_t t;
    repeat (lat - 1) @(negedge clk);
    m_ack = 1'b1; m_rdata = rdata;
    @(posedge clk);
    #1 m_ack = 1'b0; m_rdata = '0;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_output("complete_expected", 64'd0, 64'd1);
    end else begin
      t = exp_q.pop_front();
      if (!t.is_data) model_i_rdata = rdata;
      else if (!t.we) model_d_rdata = rdata;
      check_output("i_ready", 64'(i_ready), t.is_data ? 64'd0 : 64'd1);
      check_output("d_ready", 64'(d_ready), t.is_data ? 64'd1 : 64'd0);
      check_output("i_rdata", 64'(i_rdata), 64'(model_i_rdata));
      check_output("d_rdata", 64'(d_rdata), 64'(model_d_rdata));
      check_output("m_req_dropped", 64'(m_req), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_ack = 1'b0; m_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Fetch only, two-cycle backend latency
    apply_stimulus(1'b0, 1'b0, 32'h100, 32'h0);
    wait_grant();
    complete(2, 32'hDEADBEEF);
    i_req = 1'b0;
    @(negedge clk);
    check_output("i_ready_one_cycle", 64'(i_ready), 64'd0);

    // Data read to establish d_rdata
    apply_stimulus(1'b1, 1'b0, 32'h80, 32'h0);
    wait_grant();
    complete(1, 32'h12345678);
    d_req = 1'b0;
    @(negedge clk);

    // Simultaneous: data write first, fetch after the bubble
    apply_stimulus(1'b1, 1'b1, 32'h40, 32'h55);
    apply_stimulus(1'b0, 1'b0, 32'h200, 32'h0);
    wait_grant();
    complete(1, 32'hAAAA0000);
    d_req = 1'b0;
    wait_grant();
    complete(1, 32'hCAFEF00D);
    i_req = 1'b0;
    @(negedge clk);

    // Starvation: four data grants, then the waiting fetch
    apply_stimulus(1'b1, 1'b0, 32'h90, 32'h0);
    push_expect(1'b1, 1'b0, 32'h90, 32'h0);
    push_expect(1'b1, 1'b0, 32'h90, 32'h0);
    push_expect(1'b1, 1'b0, 32'h90, 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h300, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_grant();
      complete(1, 32'h1000 + 32'(k));
    end
    check_output("run_cnt_sat", 64'(dut.run_cnt), 64'd4);
    wait_grant();
    check_output("run_cnt_clear", 64'(dut.run_cnt), 64'd0);
    complete(1, 32'hF00D0000);
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);

    // Withdrawn data request still completes
    apply_stimulus(1'b1, 1'b0, 32'hA0, 32'h0);
    wait_grant();
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("withdrawn_m_req_held", 64'(m_req), 64'd1);
      check_output("withdrawn_m_addr_held", 64'(m_addr), 64'hA0);
    end
    complete(1, 32'h5A5A5A5A);
    @(negedge clk);
    check_output("withdrawn_d_ready_once", 64'(d_ready), 64'd0);

    // Stray ack in IDLE
    m_ack = 1'b1; m_rdata = 32'h0BAD0BAD;
    @(posedge clk);
    #1 m_ack = 1'b0; m_rdata = '0;
    @(negedge clk);
    check_output("stray_i_ready", 64'(i_ready), 64'd0);
    check_output("stray_d_ready", 64'(d_ready), 64'd0);
    check_output("stray_m_req", 64'(m_req), 64'd0);
    check_output("stray_state", 64'(dut.state), 64'(IDLE));
    check_output("stray_d_rdata", 64'(d_rdata), 64'(model_d_rdata));
    check_output("stray_i_rdata", 64'(i_rdata), 64'(model_i_rdata));

    // Reset in BUSY_D before the ack
    apply_stimulus(1'b1, 1'b1, 32'hB0, 32'h77);
    wait_grant();
    @(negedge clk);
    check_output("pre_reset_busy_d", 64'(dut.state), 64'(BUSY_D));
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    void'(exp_q.pop_front());
    model_i_rdata = '0;
    model_d_rdata = '0;
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_ack = 1'b1; m_rdata = 32'h77777777;
    @(posedge clk);
    #1 m_ack = 1'b0; m_rdata = '0;
    @(negedge clk);
    check_output("stale_d_ready", 64'(d_ready), 64'd0);
    check_output("stale_i_ready", 64'(i_ready), 64'd0);
    check_output("stale_m_req", 64'(m_req), 64'd0);
    check_output("stale_d_rdata", 64'(d_rdata), 64'd0);

    check_output("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address buses.
REQ-002 Parameter DATA_W, default 32, width of all data buses.
REQ-003 Parameter MAX_D_RUN, default 4, number of consecutive data grants allowed while a fetch waits.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 i_req  input  1  fetch-stage read request; held until i_ready.
REQ-008 i_addr  input  ADDR_W  fetch address.
REQ-009 i_rdata  output  DATA_W  fetched word; valid when i_ready=1.
REQ-010 i_ready  output  1  one-cycle completion pulse for the fetch port.
REQ-011 d_req  input  1  memory-stage request; held until d_ready.
REQ-012 d_we  input  1  1=write, 0=read.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  write data.
REQ-015 d_rdata  output  DATA_W  read data; valid when d_ready=1.
REQ-016 d_ready  output  1  one-cycle completion pulse for the data port.
REQ-017 m_req  output  1  backend request.
REQ-018 m_we  output  1  backend write enable.
REQ-019 m_addr  output  ADDR_W  backend address.
REQ-020 m_wdata  output  DATA_W  backend write data.
REQ-021 m_rdata  input  DATA_W  backend read data; valid with m_ack.
REQ-022 m_ack  input  1  backend completion; latency of 1 or more cycles after m_req.

Function
REQ-023 The FSM SHALL have states IDLE, BUSY_I and BUSY_D.
REQ-024 In IDLE with d_req=1, the block SHALL grant data and go to BUSY_D, unless i_req=1 and run_cnt==MAX_D_RUN, in which case it SHALL grant fetch.
REQ-025 In IDLE with only i_req=1, the block SHALL grant fetch and go to BUSY_I.
REQ-026 On grant, m_req, m_we (0 for fetch), m_addr and m_wdata SHALL be registered from the winning port and held stable until the cycle m_ack=1.
REQ-027 On m_ack in a BUSY state, the block SHALL drop m_req next edge, pulse the owner's ready for exactly one cycle, and return to IDLE.
REQ-028 On read completion, the owner's rdata SHALL register m_rdata on that edge; on write completion, d_rdata SHALL hold its previous value.
REQ-029 Minimum transaction = request cycle + grant edge + m_ack edge.
REQ-030 There SHALL be one IDLE bubble between back-to-back transactions.
REQ-031 run_cnt SHALL increment, saturating at MAX_D_RUN, on each data grant made while i_req=1.
REQ-032 run_cnt SHALL clear on any fetch grant, or on a data grant made while i_req=0.
REQ-033 m_ack in IDLE SHALL be ignored.
REQ-034 If a requester deasserts req while its transaction is BUSY, the transaction SHALL still complete and the ready pulse SHALL still be issued.
REQ-035 i_ready and d_ready SHALL never be 1 in the same cycle.

Reset
REQ-036 On reset low, the block SHALL immediately go to IDLE and clear run_cnt, m_req, m_we, m_addr, m_wdata, i_ready, d_ready, i_rdata and d_rdata to 0, including mid-transaction.
REQ-037 After reset release, the first grant SHALL occur no earlier than the first rising edge with reset high.

Structure
REQ-038 The FSM state encoding SHALL be defined in the shared pipeline package as a localparam enum (IDLE=0, BUSY_I=1, BUSY_D=2).
REQ-039 The block SHALL be a single module; the fetch and memory stages connect their stall logic to (req & ~ready).

Verification
REQ-040 Fetch only: i_req, i_addr=0x100, m_ack 2 cycles after m_req with m_rdata=0xDEADBEEF -> m_addr=0x100, m_we=0, one-cycle i_ready, i_rdata=0xDEADBEEF.
REQ-041 Simultaneous requests: i_req and d_req (write, addr 0x40, data 0x55) in the same cycle -> data granted first (m_we=1, m_wdata=0x55), d_rdata unchanged; fetch granted after the bubble.
REQ-042 Starvation: d_req held continuously with i_req=1 -> exactly 4 data grants, then a fetch grant, then run_cnt=0.
REQ-043 Mid-transaction reset: reset low while in BUSY_D before m_ack -> all outputs 0 asynchronously; after release, a stale m_ack produces no ready.
REQ-044 Withdrawn request: d_req dropped during BUSY_D -> m_req held until m_ack, d_ready still pulses once.
REQ-045 Stray ack: m_ack=1 in IDLE -> no ready pulse and no state change.
